// File: rtl/rtc_bus_reader_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencers: state encoding,
// default bus timing and the registered output bundle.
package rtc_bus_reader_pkg;

    localparam int unsigned CntWidth = 8;
    localparam int unsigned CntMax   = (1 << CntWidth) - 1;

    localparam int unsigned TSetupDefault = 2;
    localparam int unsigned TPulseDefault = 10;
    localparam int unsigned TGapDefault   = 4;

    typedef logic [CntWidth-1:0] cnt_t;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StASetup  = 3'd1,
        StAStrobe = 3'd2,
        StAHold   = 3'd3,
        StGap     = 3'd4,
        StDStrobe = 3'd5,
        StDEnd    = 3'd6,
        StDone    = 3'd7
    } state_e;

    typedef struct packed {
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       a_d_n;
        logic       ad_oe;
        logic [7:0] ad_out;
        logic       busy;
        logic       done;
    } bus_out_t;

    localparam bus_out_t OutIdle = '{
        cs_n:   1'b1,
        rd_n:   1'b1,
        wr_n:   1'b1,
        a_d_n:  1'b1,
        ad_oe:  1'b0,
        ad_out: 8'h00,
        busy:   1'b0,
        done:   1'b0
    };

    // The timer counts down to zero, so a state lasting N cycles loads N-1.
    function automatic cnt_t load_count(input int unsigned cycles);
        return cnt_t'(cycles - 1);
    endfunction

    function automatic logic is_addr_phase(input state_e s);
        return (s == StASetup) || (s == StAStrobe) || (s == StAHold);
    endfunction

endpackage

// File: rtl/rtc_bus_reader_if.sv
// Request/response and multiplexed AD-bus signals of the RTC read sequencer.
interface rtc_bus_reader_if;
    import rtc_bus_reader_pkg::*;

    logic       start;
    logic [7:0] addr;
    logic       busy;
    logic       done;
    logic [7:0] data_out;

    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d_n;

    // master: requester plus top-level AD tristate; slave: the sequencer.
    modport master (
        output start, addr, ad_in,
        input  busy, done, data_out, ad_out, ad_oe, cs_n, rd_n, wr_n, a_d_n
    );

    modport slave (
        input  start, addr, ad_in,
        output busy, done, data_out, ad_out, ad_oe, cs_n, rd_n, wr_n, a_d_n
    );

endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; zero flags the last cycle of the phase.
module rtc_phase_timer
    import rtc_bus_reader_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  cnt_t load_value,
    output logic zero
);

    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_reader.sv
// RTC read sequencer: address write phase, bus gap, then data read phase.
// Every bus output is registered from the next state so strobes cannot glitch.
module rtc_bus_reader
    import rtc_bus_reader_pkg::*;
#(
    parameter int unsigned T_SETUP = TSetupDefault,
    parameter int unsigned T_PULSE = TPulseDefault,
    parameter int unsigned T_GAP   = TGapDefault
) (
    input  logic            clk,
    input  logic            reset,
    rtc_bus_reader_if.slave bus
);

    if (T_SETUP < 1 || T_SETUP > CntMax || T_PULSE < 1 || T_PULSE > CntMax ||
        T_GAP < 1 || T_GAP > CntMax) begin : g_bad_timing
        $error("rtc_bus_reader: T_SETUP, T_PULSE and T_GAP must lie in 1..255");
    end

    localparam cnt_t LdSetup = load_count(T_SETUP);
    localparam cnt_t LdPulse = load_count(T_PULSE);
    localparam cnt_t LdGap   = load_count(T_GAP);

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    bus_out_t   out_q, out_d;

    logic tmr_load;
    cnt_t tmr_value;
    logic tmr_zero;

    rtc_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next state; the timer is reloaded on every transition into a timed state.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StASetup;
                    addr_d    = bus.addr;
                    tmr_load  = 1'b1;
                    tmr_value = LdSetup;
                end
            end
            StASetup: begin
                if (tmr_zero) begin
                    state_d   = StAStrobe;
                    tmr_load  = 1'b1;
                    tmr_value = LdPulse;
                end
            end
            StAStrobe: begin
                if (tmr_zero) begin
                    state_d   = StAHold;
                    tmr_load  = 1'b1;
                    tmr_value = LdSetup;
                end
            end
            StAHold: begin
                if (tmr_zero) begin
                    state_d   = StGap;
                    tmr_load  = 1'b1;
                    tmr_value = LdGap;
                end
            end
            StGap: begin
                if (tmr_zero) begin
                    state_d   = StDStrobe;
                    tmr_load  = 1'b1;
                    tmr_value = LdPulse;
                end
            end
            StDStrobe: begin
                if (tmr_zero) begin
                    state_d   = StDEnd;
                    tmr_load  = 1'b1;
                    tmr_value = LdSetup;
                    // Sample while RD is still low, on the edge that releases it.
                    data_d    = bus.ad_in;
                end
            end
            StDEnd: begin
                if (tmr_zero) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the next state, then registered.
    always_comb begin
        out_d      = OutIdle;
        out_d.busy = (state_d != StIdle);
        out_d.done = (state_d == StDone);
        if (is_addr_phase(state_d)) begin
            out_d.cs_n   = 1'b0;
            out_d.a_d_n  = 1'b0;
            out_d.ad_oe  = 1'b1;
            out_d.ad_out = addr_d;
            out_d.wr_n   = (state_d != StAStrobe);
        end else if (state_d == StDStrobe) begin
            out_d.cs_n = 1'b0;
            out_d.rd_n = 1'b0;
        end else if (state_d == StDEnd) begin
            out_d.cs_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= OutIdle;
            data_q <= 8'h00;
        end else begin
            out_q  <= out_d;
            data_q <= data_d;
        end
    end

    assign bus.cs_n     = out_q.cs_n;
    assign bus.rd_n     = out_q.rd_n;
    assign bus.wr_n     = out_q.wr_n;
    assign bus.a_d_n    = out_q.a_d_n;
    assign bus.ad_oe    = out_q.ad_oe;
    assign bus.ad_out   = out_q.ad_out;
    assign bus.busy     = out_q.busy;
    assign bus.done     = out_q.done;
    assign bus.data_out = data_q;

    // Bus contention and stray strobes would corrupt the RTC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(out_q.ad_oe && !out_q.rd_n))
                else $error("rtc_bus_reader: ad_oe and rd_n active together");
            assert (!out_q.cs_n || (out_q.rd_n && out_q.wr_n))
                else $error("rtc_bus_reader: strobe active with cs_n high");
        end
    end

endmodule
